pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the IF -> ID -> EX -> MEM core.
- Tracks instructions in flight in EX and MEM through an internal scoreboard.
- Generates stall, flush and bubble controls for the fetch unit, the decode register stage and the execute stage.
- Handles load-use hazards, taken-branch/jump redirects, CSR serialisation and memory wait, with a timeout into a sticky error state.

---
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// master = pipeline side (drives decode/EXU/memory status), slave = controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned PERF_W = 16
);
    logic              id_valid;
    logic [3:0]        id_type;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              ex_redirect;
    logic              mem_ack;
    logic              if_stall;
    logic              id_stall;
    logic              id_flush;
    logic              ex_bubble;
    logic              pipe_freeze;
    logic              mem_err;
    logic [1:0]        state;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_type, id_rs1, id_rs2, id_rd, ex_redirect, mem_ack,
        input  if_stall, id_stall, id_flush, ex_bubble, pipe_freeze, mem_err, state,
               stall_cycles
    );

    modport slave (
        input  id_valid, id_type, id_rs1, id_rs2, id_rd, ex_redirect, mem_ack,
        output if_stall, id_stall, id_flush, ex_bubble, pipe_freeze, mem_err, state,
               stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the IF -> ID -> EX -> MEM core.
// Keeps a two-slot scoreboard (EX, MEM) and decides stall/flush/bubble/freeze
// combinationally each cycle; memory waits that run too long latch a sticky error.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned PERF_W      = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StCsrDrain = 2'd2,
        StErr      = 2'd3
    } state_e;

    localparam logic [3:0]  TypeLoad    = 4'd7;
    localparam logic [3:0]  TypeStore   = 4'd8;
    localparam logic [3:0]  TypeCsr     = 4'd9;
    // Counter value on the last tolerated pending cycle in MEM_WAIT.
    localparam logic [15:0] TimeoutLast = 16'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [PERF_W-1:0] perf_q;

    logic              ex_valid_q, ex_load_q, ex_mem_q;
    logic [4:0]        ex_rd_q;
    logic              mem_valid_q, mem_mem_q;

    logic uses_rs1, uses_rs2;
    logic mem_pending, redirect, load_use, csr_hz, ex_take;
    logic if_stall, id_stall, id_flush, ex_bubble, pipe_freeze, mem_err;

    // Register read set of the instruction in decode.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (bus.id_type)
            4'd0, 4'd5, 4'd7, 4'd9: uses_rs1 = 1'b1;
            4'd1, 4'd6, 4'd8: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_pending = mem_valid_q && mem_mem_q && !bus.mem_ack;
    // A redirect level with nothing in EX is stale and ignored.
    assign redirect    = bus.ex_redirect && ex_valid_q;
    assign load_use    = bus.id_valid && ex_valid_q && ex_load_q && (ex_rd_q != 5'd0) &&
                         ((uses_rs1 && (bus.id_rs1 == ex_rd_q)) ||
                          (uses_rs2 && (bus.id_rs2 == ex_rd_q)));
    assign csr_hz      = bus.id_valid && (bus.id_type == TypeCsr) && (ex_valid_q || mem_valid_q);

    // Prioritised control decision and next state.
    always_comb begin
        state_d     = state_q;
        tmo_d       = '0;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        id_flush    = 1'b0;
        ex_bubble   = 1'b0;
        pipe_freeze = 1'b0;
        mem_err     = 1'b0;
        if (state_q == StErr) begin
            if_stall    = 1'b1;
            id_stall    = 1'b1;
            pipe_freeze = 1'b1;
            mem_err     = 1'b1;
        end else if (mem_pending) begin
            // Freeze wins over everything; a held redirect is acted on after the ack.
            if_stall    = 1'b1;
            id_stall    = 1'b1;
            pipe_freeze = 1'b1;
            if (state_q == StMemWait) begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_q == TimeoutLast) begin
                    state_d = StErr;
                end
            end else begin
                state_d = StMemWait;
            end
        end else if (redirect) begin
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
            state_d   = StRun;
        end else if (load_use) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
            state_d   = StRun;
        end else if (csr_hz) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
            state_d   = StCsrDrain;
        end else begin
            state_d = StRun;
        end
        if (rst) begin
            if_stall    = 1'b0;
            id_stall    = 1'b0;
            id_flush    = 1'b0;
            ex_bubble   = 1'b0;
            pipe_freeze = 1'b0;
            mem_err     = 1'b0;
        end
    end

    assign ex_take = bus.id_valid && !ex_bubble;

    // State, timeout counter, scoreboard and stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            tmo_q       <= '0;
            perf_q      <= '0;
            ex_valid_q  <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_mem_q    <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (!pipe_freeze) begin
                mem_valid_q <= ex_valid_q;
                mem_mem_q   <= ex_mem_q;
                ex_valid_q  <= ex_take;
                ex_rd_q     <= ex_take ? bus.id_rd : 5'd0;
                ex_load_q   <= ex_take && (bus.id_type == TypeLoad);
                ex_mem_q    <= ex_take &&
                               ((bus.id_type == TypeLoad) || (bus.id_type == TypeStore));
            end
            if (if_stall && (perf_q != '1)) begin
                perf_q <= perf_q + PERF_W'(1);
            end
        end
    end

    assign bus.if_stall     = if_stall;
    assign bus.id_stall     = id_stall;
    assign bus.id_flush     = id_flush;
    assign bus.ex_bubble    = ex_bubble;
    assign bus.pipe_freeze  = pipe_freeze;
    assign bus.mem_err      = mem_err;
    assign bus.state        = state_q;
    assign bus.stall_cycles = perf_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl: one table row per clock cycle,
// plus hand-written sequences for counter saturation and mid-cycle reset.
module tb_pipe_hazard_ctrl;
    localparam int unsigned TB_PERF_W = 4;

    // ctl = {if_stall, id_stall, id_flush, ex_bubble, pipe_freeze, mem_err}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b110100;
    localparam logic [5:0] C_FLUSH = 6'b001100;
    localparam logic [5:0] C_FRZ   = 6'b110010;
    localparam logic [5:0] C_ERR   = 6'b110011;

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] ty;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       redir;
        logic       ack;
        logic [5:0] ctl;
        logic [1:0] st;
        int         sc;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    pipe_hazard_ctrl_if #(.PERF_W(TB_PERF_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .PERF_W     (TB_PERF_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic [3:0] ty, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic redir,
                       input logic ack, input logic [5:0] ctl, input logic [1:0] st,
                       input int sc);
        vec_t e;
        e.rst = r; e.v = v; e.ty = ty; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.redir = redir; e.ack = ack; e.ctl = ctl; e.st = st; e.sc = sc;
        vecs.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [3:0] ty, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic redir,
                         input logic ack);
        bus.id_valid = v; bus.id_type = ty; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_rd = rd; bus.ex_redirect = redir; bus.mem_ack = ack;
    endtask

    task automatic check(input string name, input logic [5:0] ctl, input logic [1:0] st,
                         input int sc);
        logic [5:0] act;
        act = {bus.if_stall, bus.id_stall, bus.id_flush, bus.ex_bubble, bus.pipe_freeze,
               bus.mem_err};
        n_tests++;
        if (act !== ctl || bus.state !== st || bus.stall_cycles !== sc[TB_PERF_W-1:0]) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b state=%0d stall_cycles=%0d, want ctl=%b state=%0d stall_cycles=%0d",
                     name, act, bus.state, bus.stall_cycles, ctl, st, sc);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        //  rst v  ty    rs1    rs2    rd     rdr  ack  ctl      st    sc
        // Reset held with a CSR in decode, then CSR issues into an empty pipe.
        add(1, 1, 4'd9, 5'd1, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        add(1, 1, 4'd9, 5'd1, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        add(0, 1, 4'd9, 5'd1, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        // Load-use on rs2: one stall cycle.
        add(0, 1, 4'd7, 5'd1, 5'd0, 5'd5, 0, 0, C_NONE,  2'd0, 0);
        add(0, 1, 4'd1, 5'd2, 5'd5, 5'd6, 0, 0, C_STALL, 2'd0, 0);
        add(0, 1, 4'd1, 5'd2, 5'd5, 5'd6, 0, 1, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        // Load to x0: no hazard.
        add(0, 1, 4'd7, 5'd1, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd1, 5'd0, 5'd0, 5'd6, 0, 0, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        // LUI reads nothing even if its rs fields match.
        add(0, 1, 4'd7, 5'd1, 5'd0, 5'd7, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd2, 5'd7, 5'd7, 5'd8, 0, 0, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        // OP-IMM reads rs1 only; an rs2 match is not a hazard.
        add(0, 1, 4'd7, 5'd1, 5'd0, 5'd9, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd0, 5'd3, 5'd9, 5'd4, 0, 0, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, C_NONE,  2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        // Taken branch in EX, then a stale redirect with EX empty.
        add(0, 1, 4'd6, 5'd1, 5'd2, 5'd0, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd3, 1, 0, C_FLUSH, 2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 1, 0, C_NONE,  2'd0, 1);
        // Redirect beats a simultaneous load-use.
        add(0, 1, 4'd7, 5'd1, 5'd0, 5'd4, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd1, 5'd4, 5'd0, 5'd5, 1, 0, C_FLUSH, 2'd0, 1);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, C_NONE,  2'd0, 1);
        // OP-IMM, OP-IMM, CSR: CSR stalls two cycles in CSR_DRAIN.
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd1, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd2, 0, 0, C_NONE,  2'd0, 1);
        add(0, 1, 4'd9, 5'd0, 5'd0, 5'd0, 0, 0, C_STALL, 2'd0, 1);
        add(0, 1, 4'd9, 5'd0, 5'd0, 5'd0, 0, 0, C_STALL, 2'd2, 2);
        add(0, 1, 4'd9, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd2, 3);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 3);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 3);
        // Redirect flushes a waiting CSR; no drain entered.
        add(0, 1, 4'd6, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 3);
        add(0, 1, 4'd9, 5'd0, 5'd0, 5'd0, 1, 0, C_FLUSH, 2'd0, 3);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 3);
        // STORE in MEM waits 3 cycles; redirect held through freeze fires on the ack.
        add(0, 1, 4'd8, 5'd1, 5'd2, 5'd0, 0, 0, C_NONE,  2'd0, 3);
        add(0, 1, 4'd6, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 3);
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd3, 1, 0, C_FRZ,   2'd0, 3);
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd3, 1, 0, C_FRZ,   2'd1, 4);
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd3, 1, 0, C_FRZ,   2'd1, 5);
        add(0, 1, 4'd0, 5'd0, 5'd0, 5'd3, 1, 1, C_FLUSH, 2'd1, 6);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 6);
        // LOAD never acked: 4 MEM_WAIT cycles then sticky ERR, cleared by reset.
        add(0, 1, 4'd7, 5'd1, 5'd0, 5'd5, 0, 0, C_NONE,  2'd0, 6);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 6);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_FRZ,   2'd0, 6);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_FRZ,   2'd1, 7);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_FRZ,   2'd1, 8);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_FRZ,   2'd1, 9);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_FRZ,   2'd1, 10);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_ERR,   2'd3, 11);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, C_ERR,   2'd3, 12);
        add(1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        add(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);
        add(0, 1, 4'd9, 5'd2, 5'd0, 5'd0, 0, 0, C_NONE,  2'd0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].v, vecs[i].ty, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].redir,
                  vecs[i].ack);
            #2;
            check($sformatf("row%0d", i), vecs[i].ctl, vecs[i].st, vecs[i].sc);
            @(posedge clk);
            #1;
        end

        // Saturation: stuck LOAD drives into ERR and keeps if_stall high.
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 4'd7, 5'd1, 5'd0, 5'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
        end
        #1;
        check("saturate", C_ERR, 2'd3, 15);

        // Asynchronous reset between edges clears ERR at once.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", C_NONE, 2'd0, 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 4'd1, 5'd1, 5'd1, 5'd2, 1'b0, 1'b0);
        #1;
        check("post_rst", C_NONE, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
